// File: rtl/instr_fetch_ctrl_pkg.sv
// ============================================================
// instr_fetch_ctrl_pkg : shared widths and fetch entry type
// Rev 1.0
// ============================================================
`default_nettype none

package instr_fetch_ctrl_pkg;
  localparam int          ADDR_W       = 16;
  localparam int          INSTR_W      = 16;
  localparam int          INSTR_BYTES  = 2;
  localparam logic [15:0] RESET_VECTOR = 16'h0000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc;
  } fetch_entry_t;
endpackage

`default_nettype wire

// File: rtl/instr_fetch_ctrl_if.sv
// ============================================================
// instr_fetch_ctrl_if : ROM, decode, redirect and halt signals
// Rev 1.0
// ============================================================
`default_nettype none

interface instr_fetch_ctrl_if;
  import instr_fetch_ctrl_pkg::*;

  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_instr;
  logic               out_valid;
  logic               out_ready;
  logic [INSTR_W-1:0] out_instr;
  logic [ADDR_W-1:0]  out_pc;
  logic               redirect_valid;
  logic [ADDR_W-1:0]  redirect_pc;
  logic               halt;
  logic [15:0]        fetch_cnt;

  modport master (
    output mem_addr, out_valid, out_instr, out_pc, fetch_cnt,
    input  mem_instr, out_ready, redirect_valid, redirect_pc, halt
  );

  modport slave (
    input  mem_addr, out_valid, out_instr, out_pc, fetch_cnt,
    output mem_instr, out_ready, redirect_valid, redirect_pc, halt
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_ctrl_fetch_fifo.sv
// ============================================================
// fetch_fifo : synchronous prefetch FIFO, flush beats push
// Rev 1.0
// ============================================================
`default_nettype none

module fetch_fifo
  import instr_fetch_ctrl_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_push,
  input  wire logic         i_pop,
  input  wire logic         i_flush,
  input  wire fetch_entry_t i_wdata,
  output fetch_entry_t      o_rdata,
  output logic              o_full,
  output logic              o_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

  fetch_entry_t     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  assign o_full  = (r_count == C_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_wr    = i_push & ~i_flush;
  assign w_rd    = i_pop & ~o_empty & ~i_flush;

  // Storage is cleared too so the head reads as zero straight out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
// ============================================================
// instr_fetch_ctrl : PC sequencer feeding decode via prefetch FIFO
// Rev 1.0
// ============================================================
`default_nettype none

module instr_fetch_ctrl #(
  parameter int          DEPTH        = 2,
  parameter logic [15:0] RESET_VECTOR = instr_fetch_ctrl_pkg::RESET_VECTOR,
  parameter int          INSTR_W      = 16
) (
  input  wire logic          clk,
  input  wire logic          rst,
  instr_fetch_ctrl_if.master bus
);
  import instr_fetch_ctrl_pkg::fetch_entry_t;
  import instr_fetch_ctrl_pkg::INSTR_BYTES;

  logic [15:0]        r_pc;
  logic [15:0]        r_fetch_cnt;
  logic [INSTR_W-1:0] w_instr;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic               w_push;
  fetch_entry_t       w_wdata;
  fetch_entry_t       w_head;

  assign w_instr = bus.mem_instr;
  assign w_pop   = ~w_empty & bus.out_ready;
  assign w_push  = ~bus.redirect_valid & ~bus.halt & (~w_full | w_pop);
  assign w_wdata = '{instr: w_instr, pc: r_pc};

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (bus.redirect_valid),
    .i_wdata (w_wdata),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Redirect wins over sequential advance; halt simply suppresses the push.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= {RESET_VECTOR[15:1], 1'b0};
    end else if (bus.redirect_valid) begin
      r_pc <= {bus.redirect_pc[15:1], 1'b0};
    end else if (w_push) begin
      r_pc <= r_pc + 16'(INSTR_BYTES);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_cnt <= '0;
    end else if (w_push && (r_fetch_cnt != 16'hFFFF)) begin
      r_fetch_cnt <= r_fetch_cnt + 16'd1;
    end
  end

  assign bus.mem_addr  = r_pc;
  assign bus.out_valid = ~w_empty;
  assign bus.out_instr = w_head.instr;
  assign bus.out_pc    = w_head.pc;
  assign bus.fetch_cnt = r_fetch_cnt;
endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
// ============================================================
// tb_instr_fetch_ctrl : table-driven bench for instr_fetch_ctrl
// Rev 1.0
// ============================================================
`default_nettype none

module tb_instr_fetch_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  instr_fetch_ctrl_if bus();

  instr_fetch_ctrl #(.DEPTH(2), .RESET_VECTOR(16'h0000), .INSTR_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 16'hE501;
      16'h0002: rom = 16'hA502;
      16'h0004: rom = 16'h0530;
      16'h0006: rom = 16'hA583;
      16'h0008: rom = 16'h09C0;
      default:  rom = a ^ 16'h5A5A;
    endcase
  endfunction

  assign bus.mem_instr = rom(bus.mem_addr);

  typedef struct {
    bit          do_rst;
    bit          ready;
    bit          halt;
    bit          redir;
    logic [15:0] rpc;
    bit          e_valid;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic [15:0] e_addr;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit r, bit rdy, bit h, bit rd, logic [15:0] rpc,
                              bit v, logic [15:0] pc, logic [15:0] ins,
                              logic [15:0] addr, logic [15:0] cnt);
    vec_t t;
    t.do_rst = r; t.ready = rdy; t.halt = h; t.redir = rd; t.rpc = rpc;
    t.e_valid = v; t.e_pc = pc; t.e_instr = ins; t.e_addr = addr; t.e_cnt = cnt;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    bus.out_ready = 1'b0;
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 16'h0000;

    // rst, rdy, halt, redir, rpc, | valid, pc, instr, mem_addr, fetch_cnt
    // Streaming from reset
    add(1, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'hE501, 16'h0002, 16'd1);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0002, 16'hA502, 16'h0004, 16'd2);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0004, 16'h0530, 16'h0006, 16'd3);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0006, 16'hA583, 16'h0008, 16'd4);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0008, 16'h09C0, 16'h000A, 16'd5);
    // Backpressure fills the FIFO, then full+pop keeps flowing
    add(1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'hE501, 16'h0002, 16'd1);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'hE501, 16'h0004, 16'd2);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0002, 16'hA502, 16'h0006, 16'd3);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0004, 16'h0530, 16'h0008, 16'd4);
    // Redirect to odd address with two entries buffered
    add(1, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'hE501, 16'h0002, 16'd1);
    add(0, 0, 0, 0, 16'h0000, 1, 16'h0000, 16'hE501, 16'h0004, 16'd2);
    add(0, 0, 0, 1, 16'h0007, 0, 16'h0000, 16'h0000, 16'h0006, 16'd2);
    add(0, 0, 0, 0, 16'h0000, 1, 16'h0006, 16'hA583, 16'h0008, 16'd3);
    // Halt drains FIFO and freezes the address
    add(0, 0, 0, 0, 16'h0000, 1, 16'h0006, 16'hA583, 16'h000A, 16'd4);
    add(0, 1, 1, 0, 16'h0000, 1, 16'h0008, 16'h09C0, 16'h000A, 16'd4);
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h000A, 16'd4);
    add(0, 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h000A, 16'd4);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h000A, 16'h5A50, 16'h000C, 16'd5);
    // Redirect to top of address space and wrap
    add(0, 1, 0, 1, 16'hFFFE, 0, 16'h0000, 16'h0000, 16'hFFFE, 16'd5);
    add(0, 1, 0, 0, 16'h0000, 1, 16'hFFFE, 16'hA5A4, 16'h0000, 16'd6);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0000, 16'hE501, 16'h0002, 16'd7);
    // Back-to-back redirects: last wins, no pushes in between
    add(0, 1, 0, 1, 16'h0008, 0, 16'h0000, 16'h0000, 16'h0008, 16'd7);
    add(0, 1, 0, 1, 16'h0005, 0, 16'h0000, 16'h0000, 16'h0004, 16'd7);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0004, 16'h0530, 16'h0006, 16'd8);
    // Redirect while halted still moves pc and flushes
    add(0, 0, 1, 1, 16'h0002, 0, 16'h0000, 16'h0000, 16'h0002, 16'd8);
    add(0, 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000, 16'h0002, 16'd8);
    add(0, 1, 0, 0, 16'h0000, 1, 16'h0002, 16'hA502, 16'h0004, 16'd9);

    // Reset state
    #12;
    chk("rst_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("rst_addr", bus.mem_addr, 16'h0000);
    chk("rst_cnt", bus.fetch_cnt, 16'd0);
    chk("rst_instr", bus.out_instr, 16'h0000);
    chk("rst_pc", bus.out_pc, 16'h0000);

    foreach (vecs[i]) begin
      if (vecs[i].do_rst) reset_dut();
      bus.out_ready      = vecs[i].ready;
      bus.halt           = vecs[i].halt;
      bus.redirect_valid = vecs[i].redir;
      bus.redirect_pc    = vecs[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {15'd0, bus.out_valid}, {15'd0, vecs[i].e_valid});
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), bus.out_pc, vecs[i].e_pc);
        chk($sformatf("v%0d_instr", i), bus.out_instr, vecs[i].e_instr);
      end
      chk($sformatf("v%0d_addr", i), bus.mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_cnt", i), bus.fetch_cnt, vecs[i].e_cnt);
    end

    // Asynchronous reset between edges, mid-stream
    bus.out_ready = 1'b1;
    bus.halt = 1'b0;
    bus.redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #2;
    chk("async_valid", {15'd0, bus.out_valid}, 16'd0);
    chk("async_addr", bus.mem_addr, 16'h0000);
    chk("async_cnt", bus.fetch_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("restart_valid", {15'd0, bus.out_valid}, 16'd1);
    chk("restart_pc", bus.out_pc, 16'h0000);
    chk("restart_instr", bus.out_instr, 16'hE501);
    chk("restart_addr", bus.mem_addr, 16'h0002);
    chk("restart_cnt", bus.fetch_cnt, 16'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

`default_nettype wire
